// File: rtl/prog_clk_div_if.sv
// Control/status bundle for the programmable clock divider: load/enable in,
// divided clock, period tick, phase and shadow status out.
interface prog_clk_div_if #(
    parameter int unsigned W = 8
);
    logic         en;
    logic         load;
    logic [W-1:0] load_div;
    logic         load_mode;
    logic         out;
    logic         tick;
    logic [W-1:0] count;
    logic         pending;
    logic         load_err;

    modport master (
        output en, load, load_div, load_mode,
        input  out, tick, count, pending, load_err
    );

    modport slave (
        input  en, load, load_div, load_mode,
        output out, tick, count, pending, load_err
    );
endinterface

// File: rtl/prog_clk_div.sv
// Runtime-programmable integer clock divider (2..2^W-1) with square or pulse
// output; new settings are shadowed and only take effect on a period boundary.
module prog_clk_div #(
    parameter int unsigned W            = 8,
    parameter int unsigned DEFAULT_DIV  = 12,
    parameter int unsigned DEFAULT_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    prog_clk_div_if.slave bus
);
    localparam logic [W-1:0] L_DEF_DIV  = W'(DEFAULT_DIV);
    localparam logic [W-1:0] L_DEF_CNT  = W'(DEFAULT_DIV - 1);
    localparam logic         L_DEF_MODE = 1'(DEFAULT_MODE);
    localparam logic [W-1:0] L_MIN_DIV  = W'(2);

    logic [W-1:0] r_div_act;
    logic         r_mode_act;
    logic [W-1:0] r_div_pend;
    logic         r_mode_pend;
    logic         r_pending;
    logic [W-1:0] r_count;
    logic         r_out;
    logic         r_tick;
    logic         r_load_err;

    logic         w_wrap;
    logic [W-1:0] w_nxt;
    logic         w_apply;
    logic [W-1:0] w_div_new;
    logic         w_mode_new;
    logic [W:0]   w_half;
    logic         w_out_nxt;
    logic         w_load_ok;

    // Next phase and the settings that govern the period starting on this edge.
    always_comb begin
        w_wrap     = (r_count == (r_div_act - W'(1)));
        w_nxt      = w_wrap ? '0 : (r_count + W'(1));
        w_apply    = w_wrap & r_pending;
        w_div_new  = w_apply ? r_div_pend  : r_div_act;
        w_mode_new = w_apply ? r_mode_pend : r_mode_act;
        // W+1 bits so that ceil(div/2) of the largest divisor cannot overflow
        w_half     = ({1'b0, w_div_new} + (W+1)'(1)) >> 1;
        w_out_nxt  = w_mode_new ? w_wrap : ({1'b0, w_nxt} < w_half);
        w_load_ok  = bus.load & (bus.load_div >= L_MIN_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_act   <= L_DEF_DIV;
            r_mode_act  <= L_DEF_MODE;
            r_div_pend  <= '0;
            r_mode_pend <= 1'b0;
            r_pending   <= 1'b0;
            r_count     <= L_DEF_CNT;
            r_out       <= 1'b0;
            r_tick      <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_err <= bus.load & ~w_load_ok;

            if (bus.en) begin
                r_count <= w_nxt;
                r_tick  <= w_wrap;
                r_out   <= w_out_nxt;
                if (w_apply) begin
                    r_div_act  <= r_div_pend;
                    r_mode_act <= r_mode_pend;
                end
            end else begin
                r_tick <= 1'b0;
            end

            // A load on the wrap edge re-arms the shadow for the following period
            if (w_load_ok) begin
                r_div_pend  <= bus.load_div;
                r_mode_pend <= bus.load_mode;
                r_pending   <= 1'b1;
            end else if (bus.en && w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.out      = r_out;
    assign bus.tick     = r_tick;
    assign bus.count    = r_count;
    assign bus.pending  = r_pending;
    assign bus.load_err = r_load_err;
endmodule
